dcache_wt: RTL and testbench
============================

Name: dcache_wt

Overview:
- Real data-side responder for the core's memory stage; it replaces the stub data cache.
- It is a direct-mapped, write-through, no-write-allocate cache with a burst-refill engine toward a backing memory port.
- It services byte, half and word loads/stores with sign or zero extension, flags misaligned accesses, and reports completion to the core with a one-cycle valid pulse.

Parameters:
- LINES, 16, number of cache lines (power of 2, >=2)
- WORDS, 4, 32-bit words per line (power of 2, >=2)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- req  in  1  core request; sampled only when busy=0
- w_ena  in  1  1=store, 0=load
- addr  in  32  byte address
- width  in  2  00=byte, 01=half, 10=word, 11=illegal
- ext  in  1  load extension: 0=sign-extend, 1=zero-extend (matches funct3[2], LBU/LHU)
- data_in  in  32  store data; low bytes used for byte/half
- valid  out  1  one-cycle completion pulse
- err  out  1  qualified by valid; misaligned or illegal width
- data_out  out  32  load result, qualified by valid; 0 for stores and errors
- busy  out  1  1 whenever FSM is not IDLE
- mem_req  out  1  backing request; held until mem_gnt
- mem_we  out  1  backing write
- mem_addr  out  32  word-aligned; line-aligned for reads
- mem_wdata  out  32  write data, byte-lane positioned
- mem_wstrb  out  4  byte enables for writes
- mem_gnt  in  1  backing accepts the request this cycle
- mem_rvalid  in  1  one read beat valid
- mem_rdata  in  32  read beat data

Behaviour:
- Address split: offset = addr[1:0], word = addr[2 +: log2(WORDS)], index = next log2(LINES) bits, tag = remaining upper bits.
- Storage: per-line valid bit, tag register, and WORDS x 32 data registers.
- Reset (rst=0, asynchronous): FSM -> IDLE; all line valid bits cleared; valid, err, busy, mem_req, mem_we = 0; data_out, mem_addr, mem_wdata, mem_wstrb = 0.
- Reset mid-refill or mid-write aborts the operation: mem_req drops immediately and no response is issued.
- Request capture: in IDLE with req=1, addr/width/ext/w_ena/data_in are registered. While busy=1, req is ignored and the core must hold it.
- Error check: misaligned (half with addr[0]=1, word with addr[1:0]!=0) or width=11.
  - Next cycle: valid=1, err=1, data_out=0.
  - No cache or memory activity; FSM stays IDLE.
- Load hit (valid bit set and tag match in IDLE):
  - Next cycle: valid=1, err=0, data_out = extracted lane, extended per ext.
  - FSM stays IDLE, so back-to-back hits sustain 1 access/cycle.
- Load miss: IDLE -> REFILL.
  - REFILL: mem_req=1, mem_we=0, mem_addr = line base (addr with offset and word bits zeroed); hold until mem_gnt.
  - FILL: accept exactly WORDS mem_rvalid beats in ascending word order; a beat counter wraps at WORDS.
  - After the last beat: set tag and valid bit, go to RESP.
  - RESP: valid=1 with data taken from the refilled line, then return to IDLE.
  - Miss latency = 1 + grant wait + WORDS beats + 1 cycles.
- Store (hit or miss): IDLE -> WRITE.
  - WRITE: mem_req=1, mem_we=1, mem_addr = addr & ~3.
  - mem_wstrb: byte 0001<<offset; half 0011<<offset; word 1111.
  - mem_wdata = data_in replicated/shifted into the strobed lanes.
  - On hit, update only the strobed bytes of the cached word, in the WRITE entry cycle.
  - On miss, do not allocate.
  - On mem_gnt: go to RESP (valid=1, data_out=0), then IDLE.
- mem_rvalid outside FILL is ignored. mem_gnt outside REFILL/WRITE is ignored.
- Extension: byte bit 7, half bit 15 replicated when ext=0; zeros when ext=1. ext is ignored for word loads.
- Output registers: valid and err are registered and are 1 for exactly one cycle per accepted request. data_out holds its last value when valid=0.

Decomposition:
- Shared package holds:
  - width encodings (W_BYTE, W_HALF, W_WORD);
  - FSM state enum: IDLE, REFILL, FILL, WRITE, RESP;
  - backing-port opcode constants.
- One sub-module: dcache_lane, combinational. It does load lane extraction/extension, store strobe/data positioning, and misalignment detection. It is reusable by the fetch side.

Test Plan:
- Cold load word at 0x100: REFILL with mem_addr=0x100, 4 beats 0x11111111..0x44444444 -> valid once, data_out=0x11111111, err=0.
- Load byte addr 0x103 (ext=0) on that line after beat0 was 0x80FF7F01 -> next-cycle valid, data_out=0xFFFFFF80. With ext=1 -> 0x00000080.
- Store half 0xBEEF at 0x102 (hit) -> mem_addr=0x100, mem_wstrb=1100, mem_wdata[31:16]=0xBEEF. Hold mem_gnt low 3 cycles: busy stays 1. A subsequent word load returns 0xBEEFxxxx with no refill.
- Half load at 0x101, and width=11 -> valid=1, err=1, data_out=0, mem_req never asserted.
- Conflict: load 0x100 then 0x100+LINES*WORDS*4 (same index, different tag) -> second access refills and evicts. Reloading 0x100 triggers another refill.
- Assert rst=0 during the 2nd FILL beat -> mem_req=0 and busy=0 immediately, no valid pulse. Reloading 0x100 misses (valid bits cleared).

Source files
------------

// File: rtl/dcache_wt_pkg.sv
// rtl/dcache_wt_pkg.sv - shared encodings for the write-through data cache
//   width encodings, FSM state enum, backing-port opcodes
package dcache_wt_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    // backing-port opcode driven on mem_we
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REFILL,
        FILL,
        WRITE,
        RESP
    } state_e;

endpackage

// File: rtl/dcache_lane.sv
// rtl/dcache_lane.sv - combinational byte-lane helper for loads and stores
//   width_i/offset_i/ext_i : access shape
//   rword_i                : 32-bit word read from storage
//   sdata_i                : store data (low bytes used for byte/half)
//   ldata_o                : extracted and extended load value
//   wdata_o/wstrb_o        : store data positioned in lanes and byte enables
//   bad_o                  : misaligned access or illegal width
module dcache_lane
    import dcache_wt_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  offset_i,
    input  logic        ext_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] sdata_i,
    output logic [31:0] ldata_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        bad_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rword_i >> {offset_i, 3'b000};
        ldata_o = '0;
        wdata_o = '0;
        wstrb_o = '0;
        bad_o   = 1'b0;
        case (width_i)
            W_BYTE: begin
                ldata_o = {{24{~ext_i & shifted[7]}}, shifted[7:0]};
                // replication puts the byte in every lane; the strobe selects one
                wdata_o = {4{sdata_i[7:0]}};
                wstrb_o = 4'b0001 << offset_i;
            end
            W_HALF: begin
                ldata_o = {{16{~ext_i & shifted[15]}}, shifted[15:0]};
                wdata_o = {2{sdata_i[15:0]}};
                wstrb_o = 4'b0011 << offset_i;
                bad_o   = offset_i[0];
            end
            W_WORD: begin
                ldata_o = rword_i;
                wdata_o = sdata_i;
                wstrb_o = 4'b1111;
                bad_o   = |offset_i;
            end
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - direct-mapped write-through no-write-allocate data cache
//   core side   : req/w_ena/addr/width/ext/data_in in; valid/err/data_out/busy out
//   memory side : mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb out;
//                 mem_gnt/mem_rvalid/mem_rdata in
//   rst is asynchronous, active-low
module dcache_wt
    import dcache_wt_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        w_ena,
    input  logic [31:0] addr,
    input  logic [1:0]  width,
    input  logic        ext,
    input  logic [31:0] data_in,
    output logic        valid,
    output logic        err,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int WBITS = $clog2(WORDS);
    localparam int IBITS = $clog2(LINES);
    localparam int TBITS = 32 - 2 - WBITS - IBITS;
    localparam logic [WBITS-1:0] LAST_BEAT = WBITS'(WORDS - 1);

    state_e            state_q;
    logic [LINES-1:0]  lvalid_q;
    logic [TBITS-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES][WORDS];
    logic [WBITS-1:0]  beat_q;
    logic [31:0]       addr_q;
    logic [1:0]        width_q;
    logic              ext_q;
    logic              valid_q, err_q, busy_q;
    logic [31:0]       data_out_q;
    logic              mem_req_q, mem_we_q;
    logic [31:0]       mem_addr_q, mem_wdata_q;
    logic [3:0]        mem_wstrb_q;

    logic [WBITS-1:0]  in_word, cap_word;
    logic [IBITS-1:0]  in_idx, cap_idx;
    logic [TBITS-1:0]  in_tag, cap_tag;
    logic              hit;

    assign in_word  = addr[2 +: WBITS];
    assign in_idx   = addr[2+WBITS +: IBITS];
    assign in_tag   = addr[31 -: TBITS];
    assign cap_word = addr_q[2 +: WBITS];
    assign cap_idx  = addr_q[2+WBITS +: IBITS];
    assign cap_tag  = addr_q[31 -: TBITS];
    assign hit      = lvalid_q[in_idx] && (tag_q[in_idx] == in_tag);

    // In IDLE the lane helper works on the live request; afterwards on the
    // captured one. During the last fill beat the requested word may be the
    // beat on the bus, not yet in storage.
    logic [1:0]  l_width, l_off;
    logic        l_ext;
    logic [31:0] l_rword;
    logic [31:0] l_ldata, l_wdata;
    logic [3:0]  l_wstrb;
    logic        l_bad;

    always_comb begin
        if (state_q == IDLE) begin
            l_width = width;
            l_off   = addr[1:0];
            l_ext   = ext;
            l_rword = data_q[in_idx][in_word];
        end else begin
            l_width = width_q;
            l_off   = addr_q[1:0];
            l_ext   = ext_q;
            l_rword = (beat_q == cap_word) ? mem_rdata : data_q[cap_idx][cap_word];
        end
    end

    dcache_lane u_lane (
        .width_i  (l_width),
        .offset_i (l_off),
        .ext_i    (l_ext),
        .rword_i  (l_rword),
        .sdata_i  (data_in),
        .ldata_o  (l_ldata),
        .wdata_o  (l_wdata),
        .wstrb_o  (l_wstrb),
        .bad_o    (l_bad)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lvalid_q    <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            width_q     <= W_BYTE;
            ext_q       <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            data_out_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= MEM_RD;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        width_q <= width;
                        ext_q   <= ext;
                        if (l_bad) begin
                            valid_q    <= 1'b1;
                            err_q      <= 1'b1;
                            data_out_q <= '0;
                        end else if (w_ena) begin
                            state_q     <= WRITE;
                            busy_q      <= 1'b1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MEM_WR;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_wdata_q <= l_wdata;
                            mem_wstrb_q <= l_wstrb;
                        end else if (hit) begin
                            valid_q    <= 1'b1;
                            data_out_q <= l_ldata;
                        end else begin
                            // old line contents are being overwritten from now on
                            lvalid_q[in_idx] <= 1'b0;
                            state_q    <= REFILL;
                            busy_q     <= 1'b1;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= MEM_RD;
                            mem_addr_q <= {addr[31:2+WBITS], {(2+WBITS){1'b0}}};
                            beat_q     <= '0;
                        end
                    end
                end
                REFILL: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            lvalid_q[cap_idx] <= 1'b1;
                            state_q    <= RESP;
                            valid_q    <= 1'b1;
                            data_out_q <= l_ldata;
                        end
                    end
                end
                WRITE: begin
                    if (mem_gnt) begin
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= MEM_RD;
                        state_q    <= RESP;
                        valid_q    <= 1'b1;
                        data_out_q <= '0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req && !l_bad && w_ena && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (l_wstrb[b]) data_q[in_idx][in_word][8*b +: 8] <= l_wdata[8*b +: 8];
            end
        end
        if (state_q == FILL && mem_rvalid) begin
            data_q[cap_idx][beat_q] <= mem_rdata;
            if (beat_q == LAST_BEAT) tag_q[cap_idx] <= cap_tag;
        end
    end

    assign valid     = valid_q;
    assign err       = err_q;
    assign data_out  = data_out_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_dcache_wt.sv
// tb/tb_dcache_wt.sv - self-checking bench for dcache_wt
module tb_dcache_wt;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, w_ena = 1'b0, ext = 1'b0;
    logic [31:0] addr = '0, data_in = '0;
    logic [1:0]  width = 2'b00;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        valid, err, busy, mem_req, mem_we;
    logic [31:0] data_out, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int tests = 0;
    int fails = 0;

    // backing memory (byte address of word -> contents) and cache residency
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] line_of [LINES];
    bit          line_v  [LINES];

    always #5 clk = ~clk;

    dcache_wt #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .req(req), .w_ena(w_ena), .addr(addr),
        .width(width), .ext(ext), .data_in(data_in), .valid(valid),
        .err(err), .data_out(data_out), .busy(busy), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h3;
        if (mem_m.exists(k)) return mem_m[k];
        return k ^ 32'hC0DE_5A00;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] wv, input int off,
                                             input logic [1:0] w, input logic e);
        int unsigned v;
        if (w == 2'b10) return wv;
        if (w == 2'b00) begin
            v = (wv >> (8 * off)) % 256;
            if (!e && v >= 128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (wv >> (8 * off)) % 65536;
            if (!e && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One core access; the bench plays the backing memory and checks every cycle.
    task automatic access(input logic we, input logic [31:0] a, input logic [1:0] w,
                          input logic e, input logic [31:0] d, input int gdly,
                          output logic [31:0] got, output bit missed);
        bit          bad, exp_req, granted, seen;
        logic [31:0] exp_d, ln, lane, mask;
        logic [3:0]  strb;
        int          idx, off, nvalid, cyc, wcnt, beat, vcyc;
        off     = int'(a[1:0]);
        bad     = (w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00);
        ln      = a & ~32'(WORDS * 4 - 1);
        idx     = int'((a / (WORDS * 4)) % LINES);
        exp_req = !bad && (we || !(line_v[idx] && line_of[idx] == ln));
        exp_d   = (bad || we) ? 32'h0 : exp_load(mem_rd(a), off, w, e);
        strb    = (w == 2'b00) ? (4'b0001 << off) : (w == 2'b01) ? (4'b0011 << off) : 4'b1111;
        lane    = d << (8 * off);
        mask    = '0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
        got = '0; missed = 0; granted = 0; seen = 0;
        nvalid = 0; cyc = 0; wcnt = 0; beat = 0; vcyc = -1;

        @(negedge clk);
        req = 1'b1; w_ena = we; addr = a; width = w; ext = e; data_in = d;
        @(posedge clk);
        #1 req = 1'b0;
        while (cyc < 60 && (vcyc < 0 || cyc <= vcyc)) begin
            @(negedge clk);
            cyc++;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    got  = data_out;
                    vcyc = cyc;
                    check("err", {31'b0, err}, {31'b0, bad});
                    check("data_out", data_out, exp_d);
                end
            end
            if (mem_req && !granted) begin
                check("busy while mem_req", {31'b0, busy}, 32'd1);
                if (!seen) begin
                    seen = 1;
                    missed = !we;
                    check("mem_we", {31'b0, mem_we}, {31'b0, we});
                    check("mem_addr", mem_addr, we ? (a & ~32'h3) : ln);
                    if (we) begin
                        check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, strb});
                        check("mem_wdata", mem_wdata & mask, lane & mask);
                    end
                end
                if (wcnt == gdly) begin
                    mem_gnt = 1'b1;
                    granted = 1;
                    if (we) mem_m[a & ~32'h3] = (mem_rd(a) & ~mask) | (lane & mask);
                end
                wcnt++;
            end else if (granted && !we && beat < WORDS) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_rd(ln + 32'(4 * beat));
                beat++;
            end
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        check("valid pulses", 32'(nvalid), 32'd1);
        check("busy after", {31'b0, busy}, 32'd0);
        check("mem request issued", {31'b0, seen}, {31'b0, exp_req});
        if (!bad && !we) begin
            line_v[idx]  = 1;
            line_of[idx] = ln;
        end
    endtask

    logic [31:0] got;
    bit          missed;
    int          waitc;

    initial begin
        for (int i = 0; i < LINES; i++) begin line_v[i] = 0; line_of[i] = '0; end
        mem_m[32'h100] = 32'h1111_1111;
        mem_m[32'h104] = 32'h2222_2222;
        mem_m[32'h108] = 32'h3333_3333;
        mem_m[32'h10C] = 32'h4444_4444;

        // reset state
        repeat (3) @(negedge clk);
        check("rst valid", {31'b0, valid}, 32'd0);
        check("rst err", {31'b0, err}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst mem_req", {31'b0, mem_req}, 32'd0);
        check("rst mem_we", {31'b0, mem_we}, 32'd0);
        check("rst data_out", data_out, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        rst = 1'b1;

        // cold word load
        access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 1, got, missed);
        check("cold miss", {31'b0, missed}, 32'd1);
        check("cold data", got, 32'h1111_1111);

        // store word hit, then byte loads with both extensions
        access(1'b1, 32'h100, 2'b10, 1'b0, 32'h80FF_7F01, 0, got, missed);
        access(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 0, got, missed);
        check("lb sign", got, 32'hFFFF_FF80);
        check("lb hit", {31'b0, missed}, 32'd0);
        access(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 0, got, missed);
        check("lbu zero", got, 32'h0000_0080);

        // half store with slow grant, word load sees merged data without refill
        access(1'b1, 32'h102, 2'b01, 1'b0, 32'h0000_BEEF, 3, got, missed);
        access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, got, missed);
        check("merged word", got, 32'hBEEF_7F01);
        check("merged hit", {31'b0, missed}, 32'd0);

        // errors: misaligned half, illegal width load and store
        access(1'b0, 32'h101, 2'b01, 1'b0, 32'h0, 0, got, missed);
        check("misaligned data", got, 32'd0);
        access(1'b0, 32'h104, 2'b11, 1'b0, 32'h0, 0, got, missed);
        access(1'b1, 32'h108, 2'b11, 1'b0, 32'h1234_5678, 0, got, missed);
        access(1'b1, 32'h10A, 2'b10, 1'b0, 32'h1234_5678, 0, got, missed);

        // assorted hits on the resident line
        access(1'b0, 32'h10A, 2'b01, 1'b0, 32'h0, 0, got, missed);
        access(1'b0, 32'h105, 2'b00, 1'b0, 32'h0, 0, got, missed);
        access(1'b0, 32'h10C, 2'b10, 1'b1, 32'h0, 0, got, missed);
        access(1'b1, 32'h10F, 2'b00, 1'b0, 32'h0000_00A5, 1, got, missed);
        access(1'b0, 32'h10E, 2'b01, 1'b0, 32'h0, 0, got, missed);
        check("sh after sb", got, 32'hFFFF_A544);

        // conflict on the same index evicts
        access(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 2, got, missed);
        check("conflict miss", {31'b0, missed}, 32'd1);
        access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, got, missed);
        check("evicted miss", {31'b0, missed}, 32'd1);
        check("refetched word", got, 32'hBEEF_7F01);

        // back-to-back hits at one access per cycle
        @(negedge clk);
        req = 1'b1; w_ena = 1'b0; width = 2'b10; ext = 1'b0; addr = 32'h100;
        @(negedge clk);
        check("b2b valid0", {31'b0, valid}, 32'd1);
        check("b2b data0", data_out, mem_rd(32'h100));
        addr = 32'h104;
        @(negedge clk);
        check("b2b valid1", {31'b0, valid}, 32'd1);
        check("b2b data1", data_out, 32'h2222_2222);
        req = 1'b0;
        @(negedge clk);
        check("b2b idle", {31'b0, valid}, 32'd0);

        // store miss does not allocate
        access(1'b1, 32'h404, 2'b10, 1'b0, 32'hCAFE_F00D, 0, got, missed);
        access(1'b0, 32'h404, 2'b10, 1'b0, 32'h0, 0, got, missed);
        check("no-allocate miss", {31'b0, missed}, 32'd1);
        check("no-allocate data", got, 32'hCAFE_F00D);

        // reset during the second fill beat
        @(negedge clk);
        req = 1'b1; w_ena = 1'b0; width = 2'b10; addr = 32'h300;
        @(posedge clk);
        #1 req = 1'b0;
        waitc = 0;
        @(negedge clk);
        while (!mem_req && waitc < 10) begin @(negedge clk); waitc++; end
        check("abort refill seen", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0000;
        @(negedge clk);
        mem_rdata = 32'hAAAA_0001;
        check("busy before abort", {31'b0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort mem_req", {31'b0, mem_req}, 32'd0);
        check("abort valid", {31'b0, valid}, 32'd0);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no valid in reset", {31'b0, valid}, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < LINES; i++) line_v[i] = 0;
        access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, got, missed);
        check("post-reset miss", {31'b0, missed}, 32'd1);
        check("post-reset data", got, 32'hBEEF_7F01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
